sensor_tx_sched: RTL
====================

Name: sensor_tx_sched

Overview:
- Round-robin scheduler that shares the single uart_tx byte transmitter among NCH sensor channels (fake ADC and future sensors).
- Accepts one 8-bit sample per channel through a valid/ready handshake and wraps it in a 4-byte frame: HDR, ID, DATA, CHK.
- Drives the uart_tx start/data/busy interface one byte at a time and replaces the direct sample_tick→req_tx hookup in the top level.

Parameters:
- NCH, 4, number of requesting channels (1..16).
- HDR, 8'hA5, frame header byte.
- ACK_TO, 4, max cycles from tx_start until tx_busy must rise; otherwise the frame aborts.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  block enable; low forces IDLE
- ch_valid  input  NCH  per-channel sample available (level, held until accepted)
- ch_data  input  8*NCH  channel i sample at bits [8i+7:8i]
- ch_ready  output  NCH  one-hot, one-cycle accept pulse
- tx_start  output  1  one-cycle start pulse to uart_tx
- tx_data  output  8  byte to uart_tx, stable from tx_start until byte done
- tx_busy  input  1  uart_tx busy
- frame_done  output  1  one-cycle pulse after CHK byte completes
- tx_err  output  1  one-cycle pulse on ACK timeout abort

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant = NCH-1, seq = 0, byte index = 0.
- Frame format:
  - ID = {seq[3:0], ch[3:0]}
  - CHK = HDR ^ ID ^ DATA
  - seq increments mod 16 on each frame_done only. Aborted frames do not advance it.
- IDLE: if ena and any ch_valid, go to ARB next cycle.
- ARB (1 cycle):
  - Grant the first valid channel searching last_grant+1, +2, … with wrap mod NCH.
  - Pulse ch_ready[g], latch ch_data[g], set last_grant = g, byte index = 0, go to LOAD.
  - If no channel is still valid, return to IDLE with no pulse.
- LOAD: if tx_busy = 0, drive tx_data = byte[idx], pulse tx_start for 1 cycle, go to ACK. Otherwise stay in LOAD.
- ACK:
  - Wait for tx_busy = 1, then go to DONE.
  - The counter starts at tx_start. If tx_busy is not seen within ACK_TO cycles after tx_start: pulse tx_err, drop the frame, go to IDLE. last_grant keeps g.
- DONE:
  - Wait for tx_busy = 0.
  - If idx < 3: idx++ and go to LOAD.
  - Otherwise pulse frame_done, increment seq, go to IDLE.
- Minimum gap between tx_start pulses is therefore start→busy-high→busy-low→LOAD: no back-to-back starts.
- tx_data holds its value from LOAD until the next LOAD.
- ena low in any state: next state IDLE, tx_start and ch_ready forced 0, the in-flight frame is discarded. seq and last_grant are kept. The UART finishes its current byte on its own.
- A channel deasserting ch_valid before grant loses its turn silently. Only valid-at-ARB counts.
- A channel that stays valid is re-granted only after all other valid channels have been served (fairness bound: NCH frames).
- Asynchronous reset mid-frame: immediate return to reset values, no partial pulses.

Test Plan:
- Single channel: NCH=4, ch_valid=0001, ch_data[7:0]=8'h3C, bench UART model (busy 1 cycle after start, 10 cycles long) → bytes A5, 00, 3C, 99. Then frame_done, ch_ready[0] pulsed once.
- Round-robin: all four channels valid continuously with data 8'h10/11/12/13 → grant order 0,1,2,3,0. ID bytes 00, 11, 22, 33, 40 (seq wraps after 15 to 0 over 16 frames).
- Busy stuck low: tx_busy tied 0 → tx_err pulse ACK_TO cycles after the first tx_start, state IDLE, seq unchanged. Next frame reuses the same seq.
- ena drop after the second byte's tx_start → no further tx_start, no frame_done. After ena returns, the new frame starts with HDR using the unchanged seq.
- Valid withdrawn: ch_valid[2] drops one cycle before its turn → channel 2 skipped, grant goes to 3, no ch_ready[2] pulse.
- Reset asserted during DONE of byte 3 → all outputs 0 asynchronously. After release, first frame has seq=0 and starts search at channel 0.

Source files
------------

// File: rtl/sensor_tx_sched.sv
// Round-robin scheduler that frames one 8-bit sample per channel as HDR/ID/DATA/CHK
// and feeds the bytes to a single uart_tx through its start/data/busy interface.
module sensor_tx_sched #(
  parameter int          NCH    = 4,
  parameter logic [7:0]  HDR    = 8'hA5,
  parameter int          ACK_TO = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [NCH-1:0]     ch_valid,
  input  logic [8*NCH-1:0]   ch_data,
  output logic [NCH-1:0]     ch_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic               frame_done,
  output logic               tx_err
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_ACK,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    last_q, last_d;
  logic [3:0]       seq_q, seq_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic [AW-1:0]    ack_cnt_q, ack_cnt_d;
  logic [NCH-1:0]   ch_ready_q, ch_ready_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             frame_done_q, frame_done_d;
  logic             tx_err_q, tx_err_d;

  logic             found;
  logic [CW-1:0]    grant;
  logic [CW-1:0]    cand;
  logic [7:0]       id_byte;
  logic [7:0]       cur_byte;

  // Rotating search: the channel right after the last grant has top priority.
  always_comb begin
    found = 1'b0;
    grant = last_q;
    cand  = last_q;
    for (int k = 1; k <= NCH; k++) begin
      cand = CW'((int'(last_q) + k) % NCH);
      if (!found && ch_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign id_byte = {seq_q, 4'(last_q)};

  always_comb begin
    case (idx_q)
      2'd0:    cur_byte = HDR;
      2'd1:    cur_byte = id_byte;
      2'd2:    cur_byte = data_q;
      default: cur_byte = HDR ^ id_byte ^ data_q;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    last_d       = last_q;
    seq_d        = seq_q;
    idx_d        = idx_q;
    data_d       = data_q;
    ack_cnt_d    = ack_cnt_q;
    tx_data_d    = tx_data_q;
    ch_ready_d   = '0;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    tx_err_d     = 1'b0;

    case (state_q)
      S_IDLE: if (ena && |ch_valid) state_d = S_ARB;
      S_ARB: begin
        if (found) begin
          ch_ready_d = NCH'(1) << grant;
          data_d     = ch_data[int'(grant)*8 +: 8];
          last_d     = grant;
          idx_d      = 2'd0;
          state_d    = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (!tx_busy) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          ack_cnt_d  = '0;
          state_d    = S_ACK;
        end
      end
      S_ACK: begin
        if (tx_busy) begin
          state_d = S_DONE;
        end else if (ack_cnt_q == AW'(ACK_TO - 1)) begin
          tx_err_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!tx_busy) begin
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            state_d = S_LOAD;
          end else begin
            frame_done_d = 1'b1;
            seq_d        = seq_q + 4'd1;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Disable discards the in-flight frame but keeps seq and the round-robin pointer.
    if (!ena) begin
      state_d      = S_IDLE;
      last_d       = last_q;
      seq_d        = seq_q;
      ch_ready_d   = '0;
      tx_start_d   = 1'b0;
      frame_done_d = 1'b0;
      tx_err_d     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_q       <= CW'(NCH - 1);
      seq_q        <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      ack_cnt_q    <= '0;
      ch_ready_q   <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
      tx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      seq_q        <= seq_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      ack_cnt_q    <= ack_cnt_d;
      ch_ready_q   <= ch_ready_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
      tx_err_q     <= tx_err_d;
    end
  end

  assign ch_ready   = ch_ready_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign frame_done = frame_done_q;
  assign tx_err     = tx_err_q;

endmodule
